// File: rtl/bht_resolve_queue.sv
// In-order queue of outstanding branch predictions; resolves the oldest entry,
// drives the history-table update port and flushes on mispredict.
// Optional macro BHT_RESQ_STATS_EN adds saturating resolve/mispredict counters.
module bht_resolve_queue #(
    parameter int addr_width = 32,
    parameter int depth      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENQ_VALID,
    output logic                    ENQ_READY,
    input  logic [addr_width-1:0]   ENQ_PC,
    input  logic [addr_width-1:0]   ENQ_PRED_PC,
    input  logic                    RES_VALID,
    input  logic                    RES_TAKEN,
    input  logic [addr_width-1:0]   RES_NEXT_PC,
    output logic [addr_width-1:0]   UPD_PC,
    output logic                    UPD_TAKE,
    output logic                    UPD_WE,
    output logic                    MISPRED,
    output logic [addr_width-1:0]   REDIRECT_PC,
    output logic                    ERR,
`ifdef BHT_RESQ_STATS_EN
    output logic [31:0]             STAT_RESOLVED,
    output logic [31:0]             STAT_MISPRED,
`endif
    output logic [$clog2(depth):0]  COUNT
);
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [addr_width-1:0] pc;
        logic [addr_width-1:0] pred_pc;
    } entry_t;

    entry_t          mem [depth];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count_q;
    logic            enq_fire, res_fire, mis;

    assign ENQ_READY = (count_q != CW'(depth));
    assign COUNT     = count_q;
    assign enq_fire  = ENQ_VALID && ENQ_READY;
    assign res_fire  = RES_VALID && (count_q != '0);
    assign mis       = res_fire && (RES_NEXT_PC != mem[head].pred_pc);

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (!RST && enq_fire && !mis)
            mem[tail] <= '{pc: ENQ_PC, pred_pc: ENQ_PRED_PC};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            UPD_PC      <= '0;
            UPD_TAKE    <= 1'b0;
            UPD_WE      <= 1'b0;
            MISPRED     <= 1'b0;
            REDIRECT_PC <= '0;
            ERR         <= 1'b0;
        end else begin
            UPD_WE  <= res_fire;
            MISPRED <= mis;
            if (res_fire) begin
                UPD_PC   <= mem[head].pc;
                UPD_TAKE <= RES_TAKEN;
            end
            if (mis)
                REDIRECT_PC <= RES_NEXT_PC;
            if (RES_VALID && count_q == '0)
                ERR <= 1'b1;
            // A mispredict redirects fetch, so a same-cycle enqueue is dropped.
            if (mis) begin
                head    <= '0;
                tail    <= '0;
                count_q <= '0;
            end else begin
                if (enq_fire)
                    tail <= tail + PW'(1);
                if (res_fire)
                    head <= head + PW'(1);
                count_q <= count_q + CW'(enq_fire) - CW'(res_fire);
            end
        end
    end

`ifdef BHT_RESQ_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            STAT_RESOLVED <= '0;
            STAT_MISPRED  <= '0;
        end else begin
            if (res_fire && STAT_RESOLVED != '1)
                STAT_RESOLVED <= STAT_RESOLVED + 32'd1;
            if (mis && STAT_MISPRED != '1)
                STAT_MISPRED <= STAT_MISPRED + 32'd1;
        end
    end
`endif

endmodule
